acc_output: RTL and testbench
=============================

// Module: acc_output
// PURPOSE
//  Serial-to-parallel batch collector: the receive-side counterpart of the accumulator input streamer.
//  Accepts one 16-bit word per cycle from the systolic/vector stream and packs ACC_WIDTH words into a batch.
//  Presents the batch as a parallel register bank with a valid/ready handshake to the downstream consumer.
//  Applies backpressure upstream while a completed batch waits to be taken.
// PARAMETERS
//  ACC_WIDTH  4  lanes per batch (>=1); CW = $clog2(ACC_WIDTH+1) is the count width
// PORTS
//  clk           in   1            single clock, all state on posedge
//  rst           in   1            asynchronous, active-high reset
//  acc_valid_i   in   1            input word valid
//  acc_data_in   in   16           input stream word
//  acc_flush_i   in   1            close the current batch early (partial batch)
//  acc_ready_o   out  1            collector can accept a word this cycle
//  acc_valid_o   out  1            batch on acc_data_out is complete and held
//  acc_data_out  out  16 x ACC_WIDTH  batch lanes [0:ACC_WIDTH-1], lane 0 = first word received
//  acc_count_o   out  CW           number of valid lanes in the presented batch (1..ACC_WIDTH)
//  acc_ready_i   in   1            downstream takes the batch this cycle
// BEHAVIOUR
//  Reset (async, while rst=1): state=FILL, wr_ptr=0, all lanes=0, acc_valid_o=0, acc_count_o=0; acc_ready_o=0 while rst high.
//  acc_ready_o = (state==FILL) & ~rst, combinational from registered state only (no path from acc_valid_i).
//  accept = acc_valid_i & acc_ready_o. acc_valid_i with acc_ready_o=0 is ignored (word dropped by protocol: upstream must hold).
//  FILL: on accept, lane[wr_ptr] <= acc_data_in, wr_ptr <= wr_ptr+1.
//   - accept with wr_ptr==ACC_WIDTH-1 -> FULL next cycle; acc_valid_o=1, acc_count_o=ACC_WIDTH.
//   - acc_flush_i with (wr_ptr>0 or accept): -> FULL; acc_count_o = wr_ptr + accept. Same-cycle word is included.
//   - acc_flush_i with wr_ptr==0 and no accept: ignored, stay FILL.
//   - flush coinciding with the final word: identical to a normal full batch.
//  FULL: acc_ready_o=0; lanes, acc_count_o, acc_valid_o held stable; acc_flush_i ignored.
//   - acc_ready_i=1 -> FILL next cycle; acc_valid_o=0, acc_count_o=0, wr_ptr=0, all lanes cleared to 0.
//   - one bubble cycle: no word may be accepted in the same cycle the batch is taken.
//  Latency: last/flush-closing word accepted at edge N -> acc_valid_o=1 after edge N (visible cycle N+1).
//  Lanes at index >= acc_count_o read 0 in a partial batch.
//  ACC_WIDTH==1: every accept goes straight to FULL.
//  acc_ready_i while in FILL has no effect.
//  Reset mid-batch: partial contents discarded; no batch emitted.
//  Throughput: ACC_WIDTH+1 cycles per full batch with acc_ready_i held high.
// TESTING (ACC_WIDTH=4 unless noted)
//  1 Full batch: stream 0x0011,0x0022,0x0033,0x0044 on consecutive cycles, acc_ready_i=0 ->
//    acc_valid_o=1 the cycle after the 4th word; lanes={11,22,33,44}; count=4; acc_ready_o=0.
//  2 Backpressure: hold state 1 for 5 cycles with acc_valid_i=1, data=0x0055 ->
//    lanes/count unchanged; then acc_ready_i=1 -> next cycle valid_o=0, lanes=0, ready_o=1.
//  3 Partial flush: words 0xAAAA,0xBBBB, then flush alone ->
//    valid_o=1, count=2, lanes={AAAA,BBBB,0,0}.
//    Flush with word 0xCCCC on the 3rd cycle instead -> count=3.
//  4 Empty flush: flush with no words and acc_valid_i=0 -> valid_o stays 0, ready_o stays 1, wr_ptr=0.
//  5 Reset mid-operation: 2 words accepted, assert rst asynchronously between edges ->
//    outputs zero immediately; after release a full 4-word batch emits count=4 with only the new words.
//  6 Back-to-back: 3 batches with ready_i=1 always, words 1..12 ->
//    batches {1,2,3,4},{5,6,7,8},{9,10,11,12}, one ready_o=0 cycle between each.
//    Repeat once with ACC_WIDTH=1.

Source files
------------

// File: rtl/acc_output.sv
// acc_output: serial-to-parallel batch collector.
// Packs ACC_WIDTH 16-bit stream words into one batch and presents it with a
// valid/ready handshake. Upstream sees backpressure while a batch is held.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   acc_valid_i           input word valid
//   acc_data_in           input stream word
//   acc_flush_i           close the current (partial) batch early
//   acc_ready_o           collector can accept a word this cycle
//   acc_valid_o           batch on acc_data_out is complete and held
//   acc_data_out          batch lanes, lane 0 = first word received
//   acc_count_o           number of valid lanes in the presented batch
//   acc_ready_i           downstream takes the batch this cycle
module acc_output #(
    parameter int unsigned ACC_WIDTH = 4,
    localparam int unsigned CW = $clog2(ACC_WIDTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              acc_valid_i,
    input  logic [15:0]                       acc_data_in,
    input  logic                              acc_flush_i,
    output logic                              acc_ready_o,
    output logic                              acc_valid_o,
    output logic [0:ACC_WIDTH-1][15:0]        acc_data_out,
    output logic [CW-1:0]                     acc_count_o,
    input  logic                              acc_ready_i
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_d;
    logic [CW-1:0]              wr_ptr;
    logic [CW-1:0]              wr_ptr_d;
    logic [CW-1:0]              count_d;
    logic [0:ACC_WIDTH-1][15:0] lanes_d;
    logic                       accept;

    // Ready depends on registered state only, so no combinational path from acc_valid_i.
    assign acc_ready_o = (state == FILL) && !rst;
    assign accept      = acc_valid_i && acc_ready_o;
    assign acc_valid_o = (state == FULL);

    // State, write pointer, lane bank and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            wr_ptr       <= '0;
            acc_data_out <= '0;
            acc_count_o  <= '0;
        end else begin
            state        <= state_d;
            wr_ptr       <= wr_ptr_d;
            acc_data_out <= lanes_d;
            acc_count_o  <= count_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state;
        wr_ptr_d = wr_ptr;
        lanes_d  = acc_data_out;
        count_d  = acc_count_o;
        unique case (state)
            FILL: begin
                if (accept) begin
                    for (int unsigned i = 0; i < ACC_WIDTH; i++) begin
                        if (wr_ptr == CW'(i)) begin
                            lanes_d[i] = acc_data_in;
                        end
                    end
                    wr_ptr_d = wr_ptr + CW'(1);
                end
                // Final word closes the batch whether or not flush is also set.
                if (accept && (wr_ptr == CW'(ACC_WIDTH - 1))) begin
                    state_d = FULL;
                    count_d = CW'(ACC_WIDTH);
                end else if (acc_flush_i && ((wr_ptr != '0) || accept)) begin
                    state_d = FULL;
                    count_d = wr_ptr + CW'(accept);
                end
            end
            FULL: begin
                // Taking the batch costs one bubble cycle before the next word.
                if (acc_ready_i) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                    lanes_d  = '0;
                    count_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_acc_output.sv
// Bench for acc_output: directed vector table, hand sequences for reset and
// back-to-back throughput, and a randomized run against a word-queue model.
module tb_acc_output;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT 0: ACC_WIDTH = 4
    logic              v0 = 1'b0, f0 = 1'b0, ri0 = 1'b0;
    logic [15:0]       d0 = '0;
    logic              rdy0, val0;
    logic [0:3][15:0]  out0;
    logic [2:0]        cnt0;

    // DUT 1: ACC_WIDTH = 1
    logic              v1 = 1'b0, f1 = 1'b0, ri1 = 1'b0;
    logic [15:0]       d1 = '0;
    logic              rdy1, val1;
    logic [0:0][15:0]  out1;
    logic [0:0]        cnt1;

    acc_output #(.ACC_WIDTH(4)) dut0 (
        .clk(clk), .rst(rst), .acc_valid_i(v0), .acc_data_in(d0), .acc_flush_i(f0),
        .acc_ready_o(rdy0), .acc_valid_o(val0), .acc_data_out(out0),
        .acc_count_o(cnt0), .acc_ready_i(ri0)
    );

    acc_output #(.ACC_WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .acc_valid_i(v1), .acc_data_in(d1), .acc_flush_i(f1),
        .acc_ready_o(rdy1), .acc_valid_o(val1), .acc_data_out(out1),
        .acc_count_o(cnt1), .acc_ready_i(ri1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
        end
    endtask

    // Directed vector: inputs for one cycle, expected outputs after the edge.
    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        f;
        logic        ri;
        logic        ev;
        logic [2:0]  ec;
        logic [63:0] el;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [15:0] d, input logic f,
                                input logic ri, input logic ev, input logic [2:0] ec,
                                input logic [63:0] el, input logic er);
        vec_t x;
        x.v = v; x.d = d; x.f = f; x.ri = ri;
        x.ev = ev; x.ec = ec; x.el = el; x.er = er;
        vecs.push_back(x);
    endfunction

    // Reference model: words collected so far, and whether the batch is closed.
    bit          m_full [2];
    int          m_n    [2];
    logic [15:0] m_l    [2][4];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_n[k]    = 0;
            for (int j = 0; j < 4; j++) m_l[k][j] = '0;
        end
    endtask

    task automatic model_step(input int k, input int w, input logic v, input logic [15:0] d,
                              input logic f, input logic ri);
        if (!m_full[k]) begin
            if (v) begin
                m_l[k][m_n[k]] = d;
                m_n[k]++;
            end
            if (m_n[k] == w || (f && m_n[k] > 0)) m_full[k] = 1'b1;
        end else if (ri) begin
            m_full[k] = 1'b0;
            m_n[k]    = 0;
            for (int j = 0; j < 4; j++) m_l[k][j] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    int idx, nb, cyc, zeros;
    logic r;

    initial begin
        // Full batch, backpressure, partial flush, empty flush, flush on final word.
        add(1, 16'h0011, 0, 0, 0, 3'd0, {16'h0011, 16'h0, 16'h0, 16'h0}, 1);
        add(1, 16'h0022, 0, 0, 0, 3'd0, {16'h0011, 16'h0022, 16'h0, 16'h0}, 1);
        add(1, 16'h0033, 0, 0, 0, 3'd0, {16'h0011, 16'h0022, 16'h0033, 16'h0}, 1);
        add(1, 16'h0044, 0, 0, 1, 3'd4, {16'h0011, 16'h0022, 16'h0033, 16'h0044}, 0);
        for (int i = 0; i < 5; i++)
            add(1, 16'h0055, 0, 0, 1, 3'd4, {16'h0011, 16'h0022, 16'h0033, 16'h0044}, 0);
        add(0, 16'h0000, 0, 1, 0, 3'd0, 64'h0, 1);
        add(1, 16'hAAAA, 0, 0, 0, 3'd0, {16'hAAAA, 16'h0, 16'h0, 16'h0}, 1);
        add(1, 16'hBBBB, 0, 0, 0, 3'd0, {16'hAAAA, 16'hBBBB, 16'h0, 16'h0}, 1);
        add(0, 16'h0000, 1, 0, 1, 3'd2, {16'hAAAA, 16'hBBBB, 16'h0, 16'h0}, 0);
        add(0, 16'h0000, 0, 1, 0, 3'd0, 64'h0, 1);
        add(1, 16'hAAAA, 0, 0, 0, 3'd0, {16'hAAAA, 16'h0, 16'h0, 16'h0}, 1);
        add(1, 16'hBBBB, 0, 0, 0, 3'd0, {16'hAAAA, 16'hBBBB, 16'h0, 16'h0}, 1);
        add(1, 16'hCCCC, 1, 0, 1, 3'd3, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0}, 0);
        add(0, 16'h0000, 1, 1, 0, 3'd0, 64'h0, 1);
        add(0, 16'h0000, 1, 0, 0, 3'd0, 64'h0, 1);
        add(0, 16'h0000, 0, 1, 0, 3'd0, 64'h0, 1);
        add(1, 16'h0001, 0, 0, 0, 3'd0, {16'h0001, 16'h0, 16'h0, 16'h0}, 1);
        add(1, 16'h0002, 0, 0, 0, 3'd0, {16'h0001, 16'h0002, 16'h0, 16'h0}, 1);
        add(1, 16'h0003, 0, 0, 0, 3'd0, {16'h0001, 16'h0002, 16'h0003, 16'h0}, 1);
        add(1, 16'h0004, 1, 0, 1, 3'd4, {16'h0001, 16'h0002, 16'h0003, 16'h0004}, 0);
        add(1, 16'h0009, 0, 1, 0, 3'd0, 64'h0, 1);
        add(0, 16'h0000, 1, 0, 0, 3'd0, 64'h0, 1);

        // Reset state
        #2;
        chk("rst_ready", 64'(rdy0), 64'(0));
        chk("rst_valid", 64'(val0), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(rdy0), 64'(1));
        chk("post_rst_count", 64'(cnt0), 64'(0));
        chk("post_rst_lanes", 64'(out0), 64'(0));

        foreach (vecs[i]) begin
            v0 = vecs[i].v; d0 = vecs[i].d; f0 = vecs[i].f; ri0 = vecs[i].ri;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), 64'(val0), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_count", i), 64'(cnt0), 64'(vecs[i].ec));
            chk($sformatf("vec%0d_lanes", i), 64'(out0), vecs[i].el);
            chk($sformatf("vec%0d_ready", i), 64'(rdy0), 64'(vecs[i].er));
        end
        v0 = 0; f0 = 0; ri0 = 0;

        // Asynchronous reset mid-batch
        v0 = 1; d0 = 16'h0F01;
        @(posedge clk); #1;
        d0 = 16'h0F02;
        @(posedge clk); #1;
        v0 = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(val0), 64'(0));
        chk("arst_count", 64'(cnt0), 64'(0));
        chk("arst_lanes", 64'(out0), 64'(0));
        chk("arst_ready", 64'(rdy0), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            v0 = 1; d0 = 16'(i * 16'h0101);
            @(posedge clk); #1;
        end
        v0 = 0;
        chk("arst_new_valid", 64'(val0), 64'(1));
        chk("arst_new_count", 64'(cnt0), 64'(4));
        chk("arst_new_lanes", 64'(out0), {16'h0101, 16'h0202, 16'h0303, 16'h0404});
        ri0 = 1;
        @(posedge clk); #1;
        ri0 = 0;

        // Back-to-back, width 4
        ri0 = 1; idx = 1; nb = 0; cyc = 0; zeros = 0;
        while (nb < 3 && cyc < 40) begin
            v0 = 1; d0 = 16'(idx); r = rdy0;
            if (!r) zeros++;
            @(posedge clk); #1;
            cyc++;
            if (r) idx++;
            if (val0) begin
                chk("b2b4_lanes", 64'(out0),
                    {16'(4*nb+1), 16'(4*nb+2), 16'(4*nb+3), 16'(4*nb+4)});
                chk("b2b4_count", 64'(cnt0), 64'(4));
                nb++;
                if (nb == 3) chk("b2b4_cycles", 64'(cyc), 64'(14));
            end
        end
        chk("b2b4_batches", 64'(nb), 64'(3));
        chk("b2b4_bubbles", 64'(zeros), 64'(2));
        v0 = 0;
        @(posedge clk); #1;
        ri0 = 0;
        chk("b2b4_drained", 64'(val0), 64'(0));

        // Back-to-back, width 1
        ri1 = 1; idx = 1; nb = 0; cyc = 0; zeros = 0;
        while (nb < 3 && cyc < 20) begin
            v1 = 1; d1 = 16'(idx); r = rdy1;
            if (!r) zeros++;
            @(posedge clk); #1;
            cyc++;
            if (r) idx++;
            if (val1) begin
                chk("b2b1_lanes", 64'(out1), 64'(nb + 1));
                chk("b2b1_count", 64'(cnt1), 64'(1));
                nb++;
                if (nb == 3) chk("b2b1_cycles", 64'(cyc), 64'(5));
            end
        end
        chk("b2b1_batches", 64'(nb), 64'(3));
        chk("b2b1_bubbles", 64'(zeros), 64'(2));
        v1 = 0;
        @(posedge clk); #1;
        ri1 = 0;

        // Randomized run on both widths against the model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            v0 = 1'($urandom_range(0, 1)); d0 = 16'($urandom);
            f0 = ($urandom_range(0, 5) == 0); ri0 = ($urandom_range(0, 2) == 0);
            v1 = 1'($urandom_range(0, 1)); d1 = 16'($urandom);
            f1 = ($urandom_range(0, 5) == 0); ri1 = ($urandom_range(0, 2) == 0);
            chk("rnd4_ready", 64'(rdy0), 64'(!m_full[0]));
            chk("rnd1_ready", 64'(rdy1), 64'(!m_full[1]));
            model_step(0, 4, v0, d0, f0, ri0);
            model_step(1, 1, v1, d1, f1, ri1);
            @(posedge clk); #1;
            chk("rnd4_valid", 64'(val0), 64'(m_full[0]));
            chk("rnd4_count", 64'(cnt0), m_full[0] ? 64'(m_n[0]) : 64'(0));
            chk("rnd4_lanes", 64'(out0), {m_l[0][0], m_l[0][1], m_l[0][2], m_l[0][3]});
            chk("rnd1_valid", 64'(val1), 64'(m_full[1]));
            chk("rnd1_count", 64'(cnt1), m_full[1] ? 64'(m_n[1]) : 64'(0));
            chk("rnd1_lanes", 64'(out1), 64'(m_l[1][0]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
